// File: rtl/aud_i2s_tx.sv
// aud_i2s_tx -- I2S transmitter with single-entry sample holding register.
//
// Serializes one signed stereo sample pair per I2S frame. The bit clock is
// derived from clk by a divider; all state changes happen on the rising edge
// of clk. Each channel slot carries DATA_W data bits, MSB first, followed by
// SLOT_W-DATA_W zero bits. The word clock leads the data by one bit clock
// (low = left slot).
//
// Configuration macro: AUD_I2S_INVERT_EN -- when defined, each outgoing sample
// is negated after mode selection, with the most negative code saturating to
// the most positive code. When undefined, samples go out unmodified.
//
// Handshake: a sample pair is accepted on any clk edge where s_valid and
// s_ready are both high; s_ready is simply "holding register empty", so it
// never depends combinationally on s_valid.
//
// Parameters:
//   DATA_W   sample width in bits (8..32)
//   SLOT_W   bit clocks per channel slot (>= DATA_W)
//   BCLK_DIV clk cycles per bit-clock period (even, >= 2)
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en               serializer run enable
//   mode             0 stereo, 1 mono mix, 2 left-duplicate, 3 mute
//   s_left, s_right  signed sample pair
//   s_valid, s_ready sample handshake
//   underrun_clr     clears the sticky underrun flag
//   aud_bclk         I2S bit clock
//   aud_wclk         I2S word clock
//   aud_din          I2S serial data
//   frame_start      one-cycle pulse on the clk cycle a frame is loaded
//   underrun         sticky: a frame was loaded with no sample available

module aud_i2s_tx #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 16,
    parameter int BCLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              underrun_clr,
    output logic              aud_bclk,
    output logic              aud_wclk,
    output logic              aud_din,
    output logic              frame_start,
    output logic              underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = $clog2(BCLK_DIV);
    localparam int HALF    = BCLK_DIV / 2;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] WCLK_LO    = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] WCLK_HI    = CNT_W'(FRAME_W - 2);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(HALF - 1);

    logic [DIV_W-1:0]   div_q;
    logic               bclk_q, wclk_q, din_q, frame_start_q, underrun_q;
    logic               run_q;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] sr_q;
    logic               full_q;
    logic [DATA_W-1:0]  hold_l_q, hold_r_q;

    logic               tick, fall, load, push, underrun_set;
    logic [DATA_W:0]    mix_sum;
    logic [DATA_W-1:0]  sel_l, sel_r, out_l, out_r;
    logic [FRAME_W-1:0] frame;

    function automatic logic [SLOT_W-1:0] to_slot(input logic [DATA_W-1:0] x);
        to_slot = '0;
        to_slot[SLOT_W-1 -: DATA_W] = x;
    endfunction

`ifdef AUD_I2S_INVERT_EN
    function automatic logic [DATA_W-1:0] negate_sat(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] min_c;
        min_c = '0;
        min_c[DATA_W-1] = 1'b1;
        if (x == min_c) negate_sat = ~min_c;
        else            negate_sat = ~x + DATA_W'(1);
    endfunction
`endif

    // Divider counts down; bclk toggles when it reaches zero. Idle state is
    // div=0, bclk=0, so the first enabled cycle raises bclk and the first
    // fall follows after a full high phase.
    assign tick = en && (div_q == '0);
    assign fall = tick && bclk_q;
    // run_q is low until the first fall after enable, which always loads.
    assign load = fall && (!run_q || (bit_cnt_q == CNT_LAST));
    assign bit_cnt_d = load ? '0 : bit_cnt_q + CNT_W'(1);
    assign push = s_valid && !full_q;
    assign underrun_set = load && !full_q;

    // Mono mix: one extra bit of headroom, so the halved sum always fits.
    assign mix_sum = {hold_l_q[DATA_W-1], hold_l_q} + {hold_r_q[DATA_W-1], hold_r_q};

    always_comb begin
        sel_l = '0;
        sel_r = '0;
        if (full_q) begin
            case (mode)
                2'd0: begin sel_l = hold_l_q;               sel_r = hold_r_q;               end
                2'd1: begin sel_l = mix_sum[DATA_W:1];      sel_r = mix_sum[DATA_W:1];      end
                2'd2: begin sel_l = hold_l_q;               sel_r = hold_l_q;               end
                default: begin sel_l = '0;                  sel_r = '0;                     end
            endcase
        end
`ifdef AUD_I2S_INVERT_EN
        out_l = negate_sat(sel_l);
        out_r = negate_sat(sel_r);
`else
        out_l = sel_l;
        out_r = sel_r;
`endif
        frame = {to_slot(out_l), to_slot(out_r)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            bclk_q        <= 1'b0;
            wclk_q        <= 1'b0;
            din_q         <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            run_q         <= 1'b0;
            bit_cnt_q     <= '0;
            sr_q          <= '0;
            full_q        <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
        end else begin
            frame_start_q <= 1'b0;
            // Set wins over a coincident clear.
            underrun_q    <= underrun_set || (underrun_q && !underrun_clr);

            if (push) begin
                hold_l_q <= s_left;
                hold_r_q <= s_right;
                full_q   <= 1'b1;
            end

            if (!en) begin
                div_q     <= '0;
                bclk_q    <= 1'b0;
                wclk_q    <= 1'b0;
                din_q     <= 1'b0;
                run_q     <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                if (tick) begin
                    bclk_q <= ~bclk_q;
                    div_q  <= DIV_RELOAD;
                end else begin
                    div_q  <= div_q - DIV_W'(1);
                end

                if (fall) begin
                    run_q     <= 1'b1;
                    bit_cnt_q <= bit_cnt_d;
                    wclk_q    <= (bit_cnt_d >= WCLK_LO) && (bit_cnt_d <= WCLK_HI);
                    if (load) begin
                        din_q         <= frame[FRAME_W-1];
                        sr_q          <= {frame[FRAME_W-2:0], 1'b0};
                        frame_start_q <= 1'b1;
                        // push cannot coincide here: it requires !full_q.
                        if (full_q) full_q <= 1'b0;
                    end else begin
                        din_q <= sr_q[FRAME_W-1];
                        sr_q  <= {sr_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign s_ready     = !full_q;
    assign aud_bclk    = bclk_q;
    assign aud_wclk    = wclk_q;
    assign aud_din     = din_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Directed testbench for aud_i2s_tx (DATA_W=16, SLOT_W=16, BCLK_DIV=4).
// Frames are captured at bit-clock falls observed on the DUT pins and compared
// against hand-computed 32-bit frame words.

module tb_aud_i2s_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] s_left, s_right;
    logic        s_valid;
    logic        s_ready;
    logic        underrun_clr;
    logic        aud_bclk, aud_wclk, aud_din, frame_start, underrun;

    int checks = 0;
    int errors = 0;

    logic        prev_b = 1'b0;
    logic [31:0] got_din, got_wclk;

    localparam logic [31:0] WCLK_EXP = 32'h0001_FFFE;

    aud_i2s_tx #(.DATA_W(16), .SLOT_W(16), .BCLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .s_left(s_left), .s_right(s_right), .s_valid(s_valid), .s_ready(s_ready),
        .underrun_clr(underrun_clr),
        .aud_bclk(aud_bclk), .aud_wclk(aud_wclk), .aud_din(aud_din),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // bclk value just before each rising edge; a fall is prev_b=1, bclk=0.
    always @(posedge clk) prev_b <= aud_bclk;

    function automatic logic [15:0] inv(input logic [15:0] x);
`ifdef AUD_I2S_INVERT_EN
        return (x == 16'h8000) ? 16'h7FFF : (~x + 16'd1);
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Returns at the negedge following the next bclk fall.
    task automatic wait_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (prev_b && !aud_bclk) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("bclk_fall");
    endtask

    task automatic frame_begin(input string tag, input int exp_skip);
        bit ok;
        bit found;
        int skipped;
        found = 1'b0;
        skipped = 0;
        for (int k = 0; k < 40; k++) begin
            wait_fall(ok);
            if (!ok) break;
            if (frame_start) begin
                found = 1'b1;
                break;
            end
            skipped++;
        end
        chk1({tag, "_fs"}, found, 1'b1);
        chk({tag, "_skip"}, 32'(skipped), 32'(exp_skip));
        got_din  = {31'd0, aud_din};
        got_wclk = {31'd0, aud_wclk};
    endtask

    task automatic frame_rest(input string tag, input logic [31:0] exp_din);
        bit ok;
        for (int k = 1; k < 32; k++) begin
            wait_fall(ok);
            if (!ok) break;
            got_din  = {got_din[30:0], aud_din};
            got_wclk = {got_wclk[30:0], aud_wclk};
        end
        chk({tag, "_din"}, got_din, exp_din);
        chk({tag, "_wclk"}, got_wclk, WCLK_EXP);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        bit ok;
        ok = 1'b0;
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (s_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!ok) timeout("push");
    endtask

    initial begin
        bit ok;
        rst = 1'b1; en = 1'b0; mode = 2'd0;
        s_left = '0; s_right = '0; s_valid = 1'b0; underrun_clr = 1'b0;
        repeat (3) @(negedge clk);

        chk1("rst_bclk", aud_bclk, 1'b0);
        chk1("rst_wclk", aud_wclk, 1'b0);
        chk1("rst_din", aud_din, 1'b0);
        chk1("rst_fs", frame_start, 1'b0);
        chk1("rst_underrun", underrun, 1'b0);
        chk1("rst_ready", s_ready, 1'b1);

        rst = 1'b0;
        @(negedge clk);
        push(16'hA5C3, 16'h0F0F);
        chk1("ready_full", s_ready, 1'b0);
        en = 1'b1;

        // Stereo frame; mode change mid-frame applies to the next frame.
        frame_begin("f1", 0);
        chk1("f1_ready", s_ready, 1'b1);
        chk1("f1_underrun", underrun, 1'b0);
        mode = 2'd1;
        push(16'h7FFF, 16'h7FFF);
        frame_rest("f1", {inv(16'hA5C3), inv(16'h0F0F)});

        frame_begin("f2", 0);
        push(16'h8000, 16'h8000);
        frame_rest("f2", {inv(16'h7FFF), inv(16'h7FFF)});

        frame_begin("f3", 0);
        mode = 2'd2;
        push(16'h1234, 16'h5678);
        frame_rest("f3", {inv(16'h8000), inv(16'h8000)});

        frame_begin("f4", 0);
        mode = 2'd3;
        push(16'hABCD, 16'h1111);
        frame_rest("f4", {inv(16'h1234), inv(16'h1234)});

        // Mute still consumes the sample: no underrun here.
        frame_begin("f5", 0);
        mode = 2'd0;
        chk1("f5_underrun", underrun, 1'b0);
        chk1("f5_ready", s_ready, 1'b1);
        frame_rest("f5", 32'h0);

        // Empty holding register at load -> zero frame and sticky underrun.
        frame_begin("f6", 0);
        chk1("f6_underrun", underrun, 1'b1);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk1("f6_clr", underrun, 1'b0);
        push(16'h1357, 16'h2468);
        s_left = 16'h9999; s_right = 16'h8888; s_valid = 1'b1;
        chk1("f6_ready_blocked", s_ready, 1'b0);
        frame_rest("f6", 32'h0);

        // Held second push is accepted right after the load frees the entry.
        frame_begin("f7", 0);
        chk1("f7_ready", s_ready, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        chk1("f7_held", s_ready, 1'b0);
        frame_rest("f7", {inv(16'h1357), inv(16'h2468)});

        frame_begin("f8", 0);
        chk1("f8_ready", s_ready, 1'b1);
        frame_rest("f8", {inv(16'h9999), inv(16'h8888)});

        // Clear held across the underrun load: the set must win.
        underrun_clr = 1'b1;
        frame_begin("f9", 0);
        underrun_clr = 1'b0;
        chk1("clr_vs_set", underrun, 1'b1);
        chk1("f9_din0", aud_din, 1'b0);
        for (int k = 0; k < 20; k++) begin
            wait_fall(ok);
            if (!ok) break;
        end
        chk1("bit20_wclk", aud_wclk, 1'b1);
        push(16'h4444, 16'h5555);
        chk1("pre_rst_ready", s_ready, 1'b0);

        // Reset mid-frame abandons everything.
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        chk1("mid_rst_bclk", aud_bclk, 1'b0);
        chk1("mid_rst_wclk", aud_wclk, 1'b0);
        chk1("mid_rst_din", aud_din, 1'b0);
        chk1("mid_rst_fs", frame_start, 1'b0);
        chk1("mid_rst_underrun", underrun, 1'b0);
        chk1("mid_rst_ready", s_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk1("re_c1_bclk", aud_bclk, 1'b1);
        chk1("re_c1_fs", frame_start, 1'b0);
        @(negedge clk);
        chk1("re_c2_bclk", aud_bclk, 1'b1);
        chk1("re_c2_fs", frame_start, 1'b0);
        @(negedge clk);
        chk1("re_c3_fs", frame_start, 1'b1);
        chk1("re_c3_bclk", aud_bclk, 1'b0);
        chk1("re_c3_wclk", aud_wclk, 1'b0);
        chk1("re_c3_underrun", underrun, 1'b1);
        @(negedge clk);
        chk1("re_c4_fs", frame_start, 1'b0);

        // Most negative code and +1 (saturating negation when inverted).
        push(16'h8000, 16'h0001);
        frame_begin("fi", 31);
        frame_rest("fi", {inv(16'h8000), inv(16'h0001)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
